wb_data_ram_slave: RTL and testbench

- Wishbone classic-cycle responder (slave) memory for the openmips data path.
- Answers the CPU's data-side Wishbone master through wb_conmax, replacing the zero-latency data_ram.
- Programmable wait states, big-endian byte lanes, registered read data.
- Gives the CPU's stall/ack handling a real multi-cycle responder to run against.

---
 rtl/wb_data_ram_slave_pkg.sv | 31 +++
 rtl/wb_data_ram_slave_if.sv | 32 +++
 rtl/wb_byte_ram.sv | 48 ++++
 rtl/wb_data_ram_slave.sv | 156 +++++++++++++++
 tb/tb_wb_data_ram_slave.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_data_ram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_data_ram_slave_pkg
// Description : Shared bus widths, active levels and FSM encodings for the
//               Wishbone data RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_data_ram_slave_pkg;

    localparam int         c_WB_DATA_W     = 32;
    localparam int         c_WB_ADDR_W     = 32;
    localparam int         c_WB_SEL_W      = 4;

    localparam logic       c_WB_ACK_ACTIVE = 1'b1;
    localparam logic       c_WB_ERR_ACTIVE = 1'b1;

    localparam logic [1:0] c_WB_IDLE       = 2'd0;
    localparam logic [1:0] c_WB_WAIT       = 2'd1;
    localparam logic [1:0] c_WB_RESP       = 2'd2;

    // Full word, either half word, or a single byte lane.
    function automatic logic sel_is_aligned(input logic [c_WB_SEL_W-1:0] sel);
        case (sel)
            4'b1111, 4'b1100, 4'b0011,
            4'b1000, 4'b0100, 4'b0010, 4'b0001: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_data_ram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_data_ram_slave_if
// Description : Wishbone classic-cycle signal bundle between the CPU data
//               master and the data RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_data_ram_slave_if;
    import wb_data_ram_slave_pkg::*;

    logic                   wb_cyc_i;
    logic                   wb_stb_i;
    logic                   wb_we_i;
    logic [c_WB_ADDR_W-1:0] wb_adr_i;
    logic [c_WB_SEL_W-1:0]  wb_sel_i;
    logic [c_WB_DATA_W-1:0] wb_dat_i;
    logic [c_WB_DATA_W-1:0] wb_dat_o;
    logic                   wb_ack_o;
    logic                   wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface
`default_nettype wire

// File: rtl/wb_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : wb_byte_ram
// Description : Single-port synchronous word RAM with per-byte write enables
//               and a registered, enable-gated read port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_byte_ram
    import wb_data_ram_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic [c_WB_SEL_W-1:0]  i_be,
    input  logic [DEPTH_LOG2-1:0]  i_addr,
    input  logic [c_WB_DATA_W-1:0] i_wdata,
    input  logic                   i_re,
    output logic [c_WB_DATA_W-1:0] o_rdata
);

    logic [c_WB_DATA_W-1:0] r_mem [1 << DEPTH_LOG2];
    logic [c_WB_DATA_W-1:0] r_rdata;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < c_WB_SEL_W; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/wb_data_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_data_ram_slave
// Description : Wishbone classic-cycle data memory with programmable wait
//               states. Define WB_SLAVE_ERR_EN to error out-of-window
//               addresses and misaligned byte selects.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_data_ram_slave
    import wb_data_ram_slave_pkg::*;
#(
    parameter int                     DEPTH_LOG2  = 10,
    parameter int                     WAIT_STATES = 1,
    parameter logic [c_WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    wb_data_ram_slave_if.slave wb
);

    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic                   r_we;
    logic [c_WB_ADDR_W-1:0] r_adr;
    logic [c_WB_SEL_W-1:0]  r_sel;
    logic [c_WB_DATA_W-1:0] r_dat;
    logic                   r_ack;

    logic                   w_req;
    logic                   w_idle;
    logic                   w_we;
    logic [c_WB_ADDR_W-1:0] w_adr;
    logic [c_WB_SEL_W-1:0]  w_sel;
    logic [c_WB_DATA_W-1:0] w_dat;
    logic [c_WB_ADDR_W-1:0] w_offset;
    logic [DEPTH_LOG2-1:0]  w_word;
    logic                   w_err;
    logic                   w_unused;
    logic                   w_enter_resp;
    logic                   w_ram_we;
    logic                   w_ram_re;
    logic [c_WB_DATA_W-1:0] w_rdata;

    assign w_req  = wb.wb_cyc_i & wb.wb_stb_i;
    assign w_idle = (r_state == c_WB_IDLE);

    // With zero wait states the RAM access happens on the accepting edge,
    // so it must see the live bus rather than the not-yet-latched copy.
    assign w_we  = w_idle ? wb.wb_we_i  : r_we;
    assign w_adr = w_idle ? wb.wb_adr_i : r_adr;
    assign w_sel = w_idle ? wb.wb_sel_i : r_sel;
    assign w_dat = w_idle ? wb.wb_dat_i : r_dat;

    assign w_offset = w_adr - BASE_ADDR;
    assign w_word   = w_offset[DEPTH_LOG2+1:2];

`ifdef WB_SLAVE_ERR_EN
    assign w_err    = (w_offset[c_WB_ADDR_W-1:DEPTH_LOG2+2] != '0) || !sel_is_aligned(w_sel);
    assign w_unused = ^w_offset[1:0];
`else
    assign w_err    = 1'b0;
    assign w_unused = ^{w_offset[c_WB_ADDR_W-1:DEPTH_LOG2+2], w_offset[1:0]};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_WB_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = c_WB_RESP;
                    end else begin
                        w_state_nxt = c_WB_WAIT;
                        w_cnt_nxt   = c_WAIT_LOAD;
                    end
                end
            end
            c_WB_WAIT: begin
                if (!w_req) begin
                    w_state_nxt = c_WB_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = c_WB_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_WB_RESP: w_state_nxt = c_WB_IDLE;
            default:   w_state_nxt = c_WB_IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_nxt == c_WB_RESP);
    assign w_ram_we     = w_enter_resp &  w_we & ~w_err;
    assign w_ram_re     = w_enter_resp & ~w_we & ~w_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_WB_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_enter_resp & ~w_err;
            if (w_idle && w_req) begin
                r_we  <= wb.wb_we_i;
                r_adr <= wb.wb_adr_i;
                r_sel <= wb.wb_sel_i;
                r_dat <= wb.wb_dat_i;
            end
        end
    end

`ifdef WB_SLAVE_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_resp & w_err;
        end
    end

    assign wb.wb_err_o = r_err ? c_WB_ERR_ACTIVE : ~c_WB_ERR_ACTIVE;
`else
    assign wb.wb_err_o = ~c_WB_ERR_ACTIVE;
`endif

    assign wb.wb_ack_o = r_ack ? c_WB_ACK_ACTIVE : ~c_WB_ACK_ACTIVE;
    assign wb.wb_dat_o = w_rdata;

    wb_byte_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ram_we),
        .i_be    (w_sel),
        .i_addr  (w_word),
        .i_wdata (w_dat),
        .i_re    (w_ram_re),
        .o_rdata (w_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_data_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_data_ram_slave
// Description : Directed bench for wb_data_ram_slave; four instances with
//               wait states 0/2/3/4 share one master stimulus bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_data_ram_slave;

    localparam int c_NDUT = 4;
    localparam int c_WS [c_NDUT] = '{0, 2, 3, 4};
`ifdef WB_SLAVE_ERR_EN
    localparam logic c_ERR_EN = 1'b1;
`else
    localparam logic c_ERR_EN = 1'b0;
`endif

    typedef struct {
        int          dut;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          dut = 0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;

    logic [c_NDUT-1:0] ack_v;
    logic [c_NDUT-1:0] err_v;
    logic [31:0]       dat_a [c_NDUT];

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < c_NDUT; k++) begin : g_dut
        wb_data_ram_slave_if u_bus ();

        assign u_bus.wb_cyc_i = cyc & (dut == k);
        assign u_bus.wb_stb_i = stb & (dut == k);
        assign u_bus.wb_we_i  = we;
        assign u_bus.wb_adr_i = adr;
        assign u_bus.wb_sel_i = sel;
        assign u_bus.wb_dat_i = wdat;
        assign ack_v[k]       = u_bus.wb_ack_o;
        assign err_v[k]       = u_bus.wb_err_o;
        assign dat_a[k]       = u_bus.wb_dat_o;

        wb_data_ram_slave #(
            .DEPTH_LOG2  (10),
            .WAIT_STATES (c_WS[k]),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .wb  (u_bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] dd, input logic e, input logic [31:0] x);
        vec_t v;
        v.dut = d; v.we = w; v.adr = a; v.sel = s; v.dat = dd; v.exp_err = e; v.exp_dat = x;
        vecs.push_back(v);
    endtask

    // One classic cycle; latency counts rising edges from the sampling edge
    // up to and including the edge that raised ack/err.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] dd, output logic o_ack, output logic o_err,
                        output logic [31:0] o_dat, output int lat, output logic after);
        logic got;
        @(negedge clk);
        dut = d; we = w; adr = a; sel = s; wdat = dd; cyc = 1'b1; stb = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack_v[d] || err_v[d]) got = 1'b1;
        end
        o_ack = ack_v[d];
        o_err = err_v[d];
        o_dat = dat_a[d];
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        after = ack_v[d] | err_v[d];
    endtask

    initial begin
        logic        r_ack_s, r_err_s, r_after;
        logic [31:0] r_dat_s;
        int          lat, hits;

        // W=2 instance: full words, byte lanes, sel=0000, aliasing window.
        add(1, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 1'b0,     32'h0);
        add(1, 1'b0, 32'h10,   4'hF, 32'h0,        1'b0,     32'hDEADBEEF);
        add(1, 1'b1, 32'h20,   4'hF, 32'h11223344, 1'b0,     32'hDEADBEEF);
        add(1, 1'b1, 32'h20,   4'h4, 32'hAABBCCDD, 1'b0,     32'hDEADBEEF);
        add(1, 1'b0, 32'h20,   4'hF, 32'h0,        1'b0,     32'h11BB3344);
        add(1, 1'b1, 32'h20,   4'h0, 32'hFFFFFFFF, c_ERR_EN, 32'h11BB3344);
        add(1, 1'b0, 32'h22,   4'hF, 32'h0,        1'b0,     32'h11BB3344);
        add(1, 1'b1, 32'h24,   4'hF, 32'h01020304, 1'b0,     32'h11BB3344);
        add(1, 1'b1, 32'h24,   4'h3, 32'hCAFEF00D, 1'b0,     32'h11BB3344);
        add(1, 1'b1, 32'h24,   4'h8, 32'h99AABBCC, 1'b0,     32'h11BB3344);
        add(1, 1'b0, 32'h27,   4'hF, 32'h0,        1'b0,     32'h9902F00D);
        add(1, 1'b1, 32'h0,    4'hF, 32'h0BADF00D, 1'b0,     32'h9902F00D);
        add(1, 1'b1, 32'h1000, 4'hF, 32'h12345678, c_ERR_EN, 32'h9902F00D);
        add(1, 1'b0, 32'h0,    4'hF, 32'h0,        1'b0,     c_ERR_EN ? 32'h0BADF00D : 32'h12345678);
        add(1, 1'b1, 32'h24,   4'h5, 32'hFFFFFFFF, c_ERR_EN, c_ERR_EN ? 32'h0BADF00D : 32'h12345678);
        add(1, 1'b0, 32'h24,   4'hF, 32'h0,        1'b0,     c_ERR_EN ? 32'h9902F00D : 32'h99FFF0FF);
        // W=0, W=3, W=4 instances: preload for the hand-written sequences.
        add(0, 1'b1, 32'h0,    4'hF, 32'h00000A0A, 1'b0,     32'h0);
        add(0, 1'b1, 32'h4,    4'hF, 32'h0000B0B0, 1'b0,     32'h0);
        add(0, 1'b0, 32'h4,    4'hF, 32'h0,        1'b0,     32'h0000B0B0);
        add(2, 1'b1, 32'h30,   4'hF, 32'h600D600D, 1'b0,     32'h0);
        add(2, 1'b0, 32'h30,   4'hF, 32'h0,        1'b0,     32'h600D600D);
        add(3, 1'b1, 32'h8,    4'hF, 32'h00000077, 1'b0,     32'h0);
        add(3, 1'b0, 32'h8,    4'hF, 32'h0,        1'b0,     32'h00000077);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < c_NDUT; k++) begin
            check($sformatf("reset_ack_d%0d", k), 32'(ack_v[k]), 32'h0);
            check($sformatf("reset_err_d%0d", k), 32'(err_v[k]), 32'h0);
            check($sformatf("reset_dat_d%0d", k), dat_a[k], 32'h0);
        end
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].dut, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
                 r_ack_s, r_err_s, r_dat_s, lat, r_after);
            check($sformatf("v%0d_ack", i), 32'(r_ack_s), 32'(!vecs[i].exp_err));
            check($sformatf("v%0d_err", i), 32'(r_err_s), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(c_WS[vecs[i].dut] + 1));
            check($sformatf("v%0d_dat", i), r_dat_s, vecs[i].exp_dat);
            check($sformatf("v%0d_pulse_width", i), 32'(r_after), 32'h0);
        end

        // W=0 back-to-back reads with stb held through the ack.
        @(negedge clk);
        dut = 0; we = 1'b0; adr = 32'h0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); @(negedge clk);
        check("b2b_ack1", 32'(ack_v[0]), 32'h1);
        check("b2b_dat1", dat_a[0], 32'h00000A0A);
        adr = 32'h4;
        @(posedge clk); @(negedge clk);
        check("b2b_idle_gap", 32'(ack_v[0]), 32'h0);
        @(posedge clk); @(negedge clk);
        check("b2b_ack2", 32'(ack_v[0]), 32'h1);
        check("b2b_dat2", dat_a[0], 32'h0000B0B0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); @(negedge clk);
        check("b2b_ack2_width", 32'(ack_v[0]), 32'h0);

        // W=4 abort: cyc drops while counting, write must not land.
        @(negedge clk);
        dut = 3; we = 1'b1; adr = 32'h8; sel = 4'hF; wdat = 32'h5; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        cyc = 1'b0;
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_v[3] || err_v[3]) hits++;
        end
        stb = 1'b0;
        check("abort_no_ack", 32'(hits), 32'h0);
        xfer(3, 1'b0, 32'h8, 4'hF, 32'h0, r_ack_s, r_err_s, r_dat_s, lat, r_after);
        check("abort_read_ack", 32'(r_ack_s), 32'h1);
        check("abort_read_dat", r_dat_s, 32'h00000077);

        // W=3 reset while a write is pending in WAIT.
        @(negedge clk);
        dut = 2; we = 1'b1; adr = 32'h30; sel = 4'hF; wdat = 32'h00000BAD; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack_v[2]), 32'h0);
        check("rst_mid_err", 32'(err_v[2]), 32'h0);
        check("rst_mid_dat", dat_a[2], 32'h0);
        check("rst_mid_dat_other", dat_a[1], 32'h0);
        cyc = 1'b0; stb = 1'b0;
        hits = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack_v[2]) hits++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ack_v[2]) hits++;
        end
        check("rst_no_ack", 32'(hits), 32'h0);
        xfer(2, 1'b0, 32'h30, 4'hF, 32'h0, r_ack_s, r_err_s, r_dat_s, lat, r_after);
        check("rst_read_ack", 32'(r_ack_s), 32'h1);
        check("rst_read_dat", r_dat_s, 32'h600D600D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
